// File: rtl/kd_tree_wb_if.sv
// Wishbone initiator-side bundle between the KD-tree loader and the tree's slave port.
interface kd_tree_wb_if;
    logic        wbs_cyc_o;
    logic        wbs_stb_o;
    logic        wbs_we_o;
    logic [3:0]  wbs_sel_o;
    logic [31:0] wbs_adr_o;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_i;
    logic [31:0] wbs_dat_i;

    modport master (
        output wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o, wbs_adr_o, wbs_dat_o,
        input  wbs_ack_i, wbs_dat_i
    );

    modport slave (
        input  wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o, wbs_adr_o, wbs_dat_o,
        output wbs_ack_i, wbs_dat_i
    );
endinterface

// File: rtl/kd_tree_wb_loader.sv
// Streams KD-tree node records into the tree as two-beat Wishbone writes and
// optionally reads every node back, counting nodes that differ from a shadow copy.
module kd_tree_wb_loader #(
    parameter int INTERNAL_WIDTH    = 22,
    parameter int NUM_NODES         = 63,
    parameter int WB_ADDRESS_OFFSET = 495,
    parameter int TIMEOUT           = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      verify_en,
    input  logic                      node_valid,
    input  logic [INTERNAL_WIDTH-1:0] node_data,
    output logic                      node_ready,
    output logic                      wb_mode,
    kd_tree_wb_if.master              wb,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [5:0]                mismatch_count,
    output logic [5:0]                fail_index
);

    localparam int HALF_W = INTERNAL_WIDTH / 2;
    localparam int IDX_W  = 6;
    localparam int TMO_W  = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NODES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_WR_LO = 3'd2;
    localparam logic [2:0] ST_WR_HI = 3'd3;
    localparam logic [2:0] ST_RD_LO = 3'd4;
    localparam logic [2:0] ST_RD_HI = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;
    localparam logic [2:0] ST_ERR   = 3'd7;

    logic [2:0]                state;
    logic [INTERNAL_WIDTH-1:0] rec;
    logic [IDX_W-1:0]          widx;
    logic [IDX_W-1:0]          ridx;
    logic                      verify_q;
    logic [TMO_W-1:0]          tcnt;
    logic                      node_mis;
    logic [INTERNAL_WIDTH-1:0] shadow [NUM_NODES];
    logic [INTERNAL_WIDTH-1:0] shadow_rd;

    logic              is_wr;
    logic              is_rd;
    logic              stb;
    logic              hi_half;
    logic [IDX_W-1:0]  cur_idx;
    logic [HALF_W-1:0] data_half;
    logic [HALF_W-1:0] rd_half;
    logic              unused_dat_hi;

    assign shadow_rd     = shadow[ridx];
    assign rd_half       = wb.wbs_dat_i[HALF_W-1:0];
    assign unused_dat_hi = ^wb.wbs_dat_i[31:HALF_W];

    // Every bus and status output is decoded from registered state, so all are 0 in IDLE.
    assign is_wr     = (state == ST_WR_LO) || (state == ST_WR_HI);
    assign is_rd     = (state == ST_RD_LO) || (state == ST_RD_HI);
    assign stb       = is_wr || is_rd;
    assign hi_half   = (state == ST_WR_HI) || (state == ST_RD_HI);
    assign cur_idx   = is_wr ? widx : ridx;
    assign data_half = (state == ST_WR_LO) ? rec[HALF_W-1:0] :
                       (state == ST_WR_HI) ? rec[INTERNAL_WIDTH-1:HALF_W] : '0;

    assign wb.wbs_cyc_o = stb;
    assign wb.wbs_stb_o = stb;
    assign wb.wbs_we_o  = is_wr;
    assign wb.wbs_sel_o = stb ? 4'hF : 4'h0;
    assign wb.wbs_adr_o = stb ? (32'(WB_ADDRESS_OFFSET) + 32'(cur_idx)) : 32'd0;
    assign wb.wbs_dat_o = stb ? {{(31 - HALF_W){1'b0}}, hi_half, data_half} : 32'd0;

    assign node_ready = (state == ST_FETCH);
    assign busy       = (state != ST_IDLE);
    assign wb_mode    = (state != ST_IDLE);
    assign done       = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (state == ST_FETCH && node_valid) begin
            shadow[widx] <= node_data;
        end
    end

    // The low write half is a fire-and-forget beat; every other beat waits for
    // ack with a timeout counter that restarts on each beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            rec            <= '0;
            widx           <= '0;
            ridx           <= '0;
            verify_q       <= 1'b0;
            tcnt           <= '0;
            node_mis       <= 1'b0;
            error          <= 1'b0;
            mismatch_count <= '0;
            fail_index     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        verify_q       <= verify_en;
                        widx           <= '0;
                        ridx           <= '0;
                        mismatch_count <= '0;
                        fail_index     <= '0;
                        error          <= 1'b0;
                        state          <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (node_valid) begin
                        rec   <= node_data;
                        state <= ST_WR_LO;
                    end
                end
                ST_WR_LO: begin
                    tcnt  <= '0;
                    state <= ST_WR_HI;
                end
                ST_WR_HI: begin
                    if (wb.wbs_ack_i) begin
                        tcnt <= '0;
                        if (widx == LAST_IDX) begin
                            ridx  <= '0;
                            state <= verify_q ? ST_RD_LO : ST_DONE;
                        end else begin
                            widx  <= widx + 1'b1;
                            state <= ST_FETCH;
                        end
                    end else if (tcnt == TMO_LAST) begin
                        error <= 1'b1;
                        state <= ST_ERR;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                ST_RD_LO: begin
                    if (wb.wbs_ack_i) begin
                        node_mis <= (rd_half != shadow_rd[HALF_W-1:0]);
                        tcnt     <= '0;
                        state    <= ST_RD_HI;
                    end else if (tcnt == TMO_LAST) begin
                        error <= 1'b1;
                        state <= ST_ERR;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                ST_RD_HI: begin
                    if (wb.wbs_ack_i) begin
                        if (node_mis || (rd_half != shadow_rd[INTERNAL_WIDTH-1:HALF_W])) begin
                            if (mismatch_count == '0) begin
                                fail_index <= ridx;
                            end
                            if (mismatch_count != '1) begin
                                mismatch_count <= mismatch_count + 1'b1;
                            end
                        end
                        tcnt <= '0;
                        if (ridx == LAST_IDX) begin
                            state <= ST_DONE;
                        end else begin
                            ridx  <= ridx + 1'b1;
                            state <= ST_RD_LO;
                        end
                    end else if (tcnt == TMO_LAST) begin
                        error <= 1'b1;
                        state <= ST_ERR;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                ST_ERR:  state <= ST_DONE;
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kd_tree_wb_loader.sv
// Scoreboard bench for kd_tree_wb_loader: a zero-wait tree slave with stall and
// readback-corruption knobs; expected write beats are queued as records are accepted.
module tb_kd_tree_wb_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        verify_en;
    logic        node_valid;
    logic [21:0] node_data;
    logic        node_ready;
    logic        wb_mode;
    logic        busy;
    logic        done;
    logic        error;
    logic [5:0]  mismatch_count;
    logic [5:0]  fail_index;

    kd_tree_wb_if wb ();

    kd_tree_wb_loader dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .verify_en      (verify_en),
        .node_valid     (node_valid),
        .node_data      (node_data),
        .node_ready     (node_ready),
        .wb_mode        (wb_mode),
        .wb             (wb),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .mismatch_count (mismatch_count),
        .fail_index     (fail_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int check_count = 0;
    int err_count   = 0;

    logic [71:0] exp_q [$];
    logic [21:0] tree_mem [64];
    logic [10:0] lo_pend;
    logic [63:0] corrupt;
    logic        stall_en;
    logic [31:0] stall_node;
    logic [31:0] sl_idx;
    logic [31:0] mon_idx;
    logic [71:0] e_beat;

    int wr_beats;
    int rd_beats;
    int done_count;
    int stall_cycles;

    task automatic checkOutput(input string tag, input logic [71:0] got, input logic [71:0] exp);
        check_count++;
        if (got !== exp) begin
            err_count++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [21:0] make_rec(input int n);
        return {11'(n + 100), 11'(n)};
    endfunction

    // Tree slave: never acks the low write half, acks everything else at once unless stalled.
    assign sl_idx = wb.wbs_adr_o - 32'd495;
    always_comb begin
        wb.wbs_ack_i = 1'b0;
        wb.wbs_dat_i = 32'd0;
        if (wb.wbs_stb_o && sl_idx < 32'd63) begin
            if (wb.wbs_we_o) begin
                wb.wbs_ack_i = wb.wbs_dat_o[11] && !(stall_en && sl_idx == stall_node);
            end else begin
                wb.wbs_ack_i = 1'b1;
                if (wb.wbs_dat_o[11])
                    wb.wbs_dat_i[10:0] = tree_mem[sl_idx[5:0]][21:11] ^ (corrupt[sl_idx[5:0]] ? 11'h400 : 11'h000);
                else
                    wb.wbs_dat_i[10:0] = tree_mem[sl_idx[5:0]][10:0];
            end
        end
    end

    // Bus monitor: compares each completed write beat against the scoreboard queue.
    always @(negedge clk) begin
        if (done) done_count++;
        if (wb.wbs_stb_o) begin
            mon_idx = wb.wbs_adr_o - 32'd495;
            if (wb.wbs_we_o) begin
                if (!wb.wbs_dat_o[11] || wb.wbs_ack_i) begin
                    wr_beats++;
                    checkOutput("wr_expected", 72'(exp_q.size() != 0), 72'd1);
                    if (exp_q.size() != 0) begin
                        e_beat = exp_q.pop_front();
                        checkOutput("wr_beat", {4'h0, wb.wbs_sel_o, wb.wbs_adr_o, wb.wbs_dat_o}, e_beat);
                    end
                    if (!wb.wbs_dat_o[11]) lo_pend = wb.wbs_dat_o[10:0];
                    else if (mon_idx < 32'd63) tree_mem[mon_idx[5:0]] = {wb.wbs_dat_o[10:0], lo_pend};
                end else if (stall_en && mon_idx == stall_node) begin
                    stall_cycles++;
                end
            end else if (wb.wbs_ack_i) begin
                rd_beats++;
            end
        end
    end

    task automatic clear_stats();
        wr_beats     = 0;
        rd_beats     = 0;
        done_count   = 0;
        stall_cycles = 0;
        exp_q.delete();
    endtask

    // One load; cycles counts from the cycle start is high to the done cycle.
    task automatic applyStimulus(input bit ver, input bit gaps, input bit pulse_busy, input int rst_node,
                                 output int cycles, output bit got_done, output bit reset_hit);
        int n;
        n         = 0;
        got_done  = 1'b0;
        reset_hit = 1'b0;
        @(negedge clk);
        start      = 1'b1;
        verify_en  = ver;
        node_valid = 1'b0;
        @(negedge clk);
        start  = 1'b0;
        cycles = 1;
        checkOutput("start_clears", {error, mismatch_count, fail_index}, 72'd0);
        while (cycles < 2000) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (rst_node >= 0 && wb.wbs_stb_o && wb.wbs_we_o && wb.wbs_dat_o[11] &&
                wb.wbs_adr_o == 32'(495 + rst_node)) begin
                rst_n = 1'b0;
                @(negedge clk);
                checkOutput("rst_mid_strobes", {wb.wbs_cyc_o, wb.wbs_stb_o, wb.wbs_we_o, wb.wbs_sel_o}, 72'd0);
                checkOutput("rst_mid_busy", {busy, wb_mode, done}, 72'd0);
                rst_n     = 1'b1;
                reset_hit = 1'b1;
                break;
            end
            if (n < 63 && (!gaps || $urandom_range(0, 2) != 0)) begin
                node_valid = 1'b1;
                node_data  = make_rec(n);
            end else begin
                node_valid = 1'b0;
            end
            if (pulse_busy) start = ($urandom_range(0, 7) == 0);
            if (node_valid && node_ready) begin
                exp_q.push_back({8'h0F, 32'(495 + n), 20'd0, 1'b0, 11'(n)});
                exp_q.push_back({8'h0F, 32'(495 + n), 20'd0, 1'b1, 11'(n + 100)});
                n++;
            end
            @(negedge clk);
            cycles++;
        end
        node_valid = 1'b0;
        start      = 1'b0;
        checkOutput("done_or_reset_seen", 72'(got_done || reset_hit), 72'd1);
        repeat (2) @(negedge clk);
    endtask

    int cycles;
    bit got_done;
    bit reset_hit;

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        verify_en  = 1'b0;
        node_valid = 1'b0;
        node_data  = '0;
        stall_en   = 1'b0;
        stall_node = 32'd0;
        corrupt    = '0;
        lo_pend    = '0;
        for (int i = 0; i < 64; i++) tree_mem[i] = '0;
        clear_stats();
        repeat (3) @(negedge clk);
        checkOutput("rst_strobes", {wb.wbs_cyc_o, wb.wbs_stb_o, wb.wbs_we_o, wb.wbs_sel_o}, 72'd0);
        checkOutput("rst_adr_dat", {wb.wbs_adr_o, wb.wbs_dat_o}, 72'd0);
        checkOutput("rst_status", {node_ready, wb_mode, busy, done, error}, 72'd0);
        checkOutput("rst_counts", {mismatch_count, fail_index}, 72'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] plain load, zero-wait slave");
        clear_stats();
        applyStimulus(1'b0, 1'b0, 1'b0, -1, cycles, got_done, reset_hit);
        checkOutput("t1_done_cycle", 72'(cycles), 72'd190);
        checkOutput("t1_wr_beats", 72'(wr_beats), 72'd126);
        checkOutput("t1_rd_beats", 72'(rd_beats), 72'd0);
        checkOutput("t1_error", 72'(error), 72'd0);
        checkOutput("t1_q_empty", 72'(exp_q.size()), 72'd0);
        checkOutput("t1_done_once", 72'(done_count), 72'd1);
        checkOutput("t1_mem62", 72'(tree_mem[62]), 72'(make_rec(62)));

        $display("[TB] load with verify, faithful slave");
        clear_stats();
        applyStimulus(1'b1, 1'b0, 1'b0, -1, cycles, got_done, reset_hit);
        checkOutput("t2_done_cycle", 72'(cycles), 72'd316);
        checkOutput("t2_rd_beats", 72'(rd_beats), 72'd126);
        checkOutput("t2_mismatch", 72'(mismatch_count), 72'd0);
        checkOutput("t2_done_once", 72'(done_count), 72'd1);
        checkOutput("t2_error", 72'(error), 72'd0);

        $display("[TB] verify with node 17 corrupted");
        clear_stats();
        corrupt[17] = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, -1, cycles, got_done, reset_hit);
        checkOutput("t3_mismatch", 72'(mismatch_count), 72'd1);
        checkOutput("t3_fail_index", 72'(fail_index), 72'd17);

        $display("[TB] verify with nodes 5 and 40 corrupted");
        clear_stats();
        corrupt     = '0;
        corrupt[5]  = 1'b1;
        corrupt[40] = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, -1, cycles, got_done, reset_hit);
        checkOutput("t3b_mismatch", 72'(mismatch_count), 72'd2);
        checkOutput("t3b_fail_index", 72'(fail_index), 72'd5);
        corrupt = '0;

        $display("[TB] slave never acks high half of node 3");
        clear_stats();
        stall_en   = 1'b1;
        stall_node = 32'd3;
        applyStimulus(1'b0, 1'b0, 1'b0, -1, cycles, got_done, reset_hit);
        checkOutput("t4_stall_cycles", 72'(stall_cycles), 72'd15);
        checkOutput("t4_done_cycle", 72'(cycles), 72'd28);
        checkOutput("t4_error", 72'(error), 72'd1);
        checkOutput("t4_done_once", 72'(done_count), 72'd1);
        checkOutput("t4_q_left", 72'(exp_q.size()), 72'd1);
        stall_en = 1'b0;

        $display("[TB] gappy stream with start pulses while busy");
        clear_stats();
        applyStimulus(1'b0, 1'b1, 1'b1, -1, cycles, got_done, reset_hit);
        checkOutput("t5_wr_beats", 72'(wr_beats), 72'd126);
        checkOutput("t5_q_empty", 72'(exp_q.size()), 72'd0);
        checkOutput("t5_error", 72'(error), 72'd0);
        repeat (10) @(negedge clk);
        checkOutput("t5_idle_after", {busy, wb_mode}, 72'd0);
        checkOutput("t5_no_extra", 72'(wr_beats), 72'd126);
        checkOutput("t5_done_once", 72'(done_count), 72'd1);

        $display("[TB] reset during high write of node 30, then full load");
        clear_stats();
        applyStimulus(1'b0, 1'b0, 1'b0, 30, cycles, got_done, reset_hit);
        checkOutput("t6_reset_hit", 72'(reset_hit), 72'd1);
        checkOutput("t6_idle_after_rst", {busy, wb_mode, wb.wbs_stb_o}, 72'd0);
        clear_stats();
        applyStimulus(1'b0, 1'b0, 1'b0, -1, cycles, got_done, reset_hit);
        checkOutput("t6_done_cycle", 72'(cycles), 72'd190);
        checkOutput("t6_wr_beats", 72'(wr_beats), 72'd126);
        checkOutput("t6_q_empty", 72'(exp_q.size()), 72'd0);

        $display("CHECKS %0d ERRORS %0d", check_count, err_count);
        $finish;
    end

endmodule
